ps2_key_event_decoder: RTL and testbench
========================================

// Module: ps2_key_event_decoder
// PURPOSE
//  Parametrised successor to the single-key decoder: parses the raw PS/2 set-2 byte stream
//  (E0/F0 prefixes, 0xAA BAT) itself, keeps a 512-bit key_down map and queues make/break/repeat
//  events in a show-ahead FIFO with valid/ready pop. Adds host-side typematic repeat and a prefix
//  timeout. Sits between the PS/2 byte receiver and game/control logic.
// PARAMETERS
//  FIFO_DEPTH      8           event queue entries; power of 2, >=2
//  REPEAT_DELAY    50_000_000  cycles from make to first repeat; 0 disables repeat
//  REPEAT_RATE     10_000_000  cycles between subsequent repeats; >=1
//  PREFIX_TIMEOUT  2_000_000   cycles a pending E0/F0 prefix survives without a next byte
// PORTS
//  clk          in   1    system clock
//  rst_n        in   1    asynchronous reset, active-low
//  rx_valid     in   1    one-cycle strobe: rx_data holds a received byte
//  rx_data      in   8    received PS/2 byte
//  key_down     out  512  bit {ext,code} set while key is held
//  last_change  out  9    {ext,code} of the most recent accepted make/break
//  evt_valid    out  1    FIFO head valid
//  evt_data     out  11   {repeat, make, ext, code[7:0]}
//  evt_ready    in   1    pop head when evt_valid && evt_ready
//  fifo_level   out  $clog2(FIFO_DEPTH)+1  entries held
//  overflow     out  1    sticky: an event was dropped on full
//  ovf_clr      in   1    clears overflow (set wins if same cycle)
// BEHAVIOUR
//  - Reset (rst_n low, any time, incl. mid-sequence): all outputs 0, FIFO empty, parser IDLE,
//    repeat idle, counters 0. Everything below acts only on cycles with rst_n high.
//  - Parser states IDLE, EXT, BRK, EXT_BRK. On rx_valid:
//    E0: IDLE->EXT, BRK->EXT_BRK; F0: IDLE->BRK, EXT->EXT_BRK; repeat of same prefix: no change.
//    AA in IDLE: BAT -> clear key_down, cancel repeat, no event. AA after prefix = ordinary code.
//    E1,FA,FE,EE,FC,00,FF: dropped, parser -> IDLE.
//    other byte: completes code {ext,byte}, make = !brk; parser -> IDLE.
//  - Prefix timer: reloaded on every prefix byte; expiry in non-IDLE -> IDLE, prefix discarded.
//  - Completed code at cycle N: key_down/last_change update at N+1; event visible on evt_valid
//    at N+1 when FIFO was empty (registered head).
//  - Filtering: make of a key already down (device typematic) -> no event, no map change;
//    break of a key not down -> no event. Filtered codes do not update last_change.
//  - Repeat: accepted make loads rep_key and counter=REPEAT_DELAY. Counter decrements each cycle;
//    at 0 with rep_key still down -> enqueue {1,1,rep_key}, reload REPEAT_RATE. Break of rep_key
//    or BAT cancels. Make of another key retargets and reloads.
//  - Simultaneous parsed event and repeat due: parsed event enqueued; repeat held at 0 and
//    enqueued next cycle unless cancelled/retargeted by the parsed event.
//  - FIFO full: push dropped, overflow set; push+pop in same cycle when full: both occur, level
//    unchanged, no overflow. Pop when empty ignored. Pointers wrap modulo FIFO_DEPTH.
//  - evt_data stable while evt_valid && !evt_ready.
// STRUCTURE
//  - ps2_pkg: scan constants (SC_EXT=E0, SC_BRK=F0, SC_BAT=AA, ignore list), parser state enum,
//    event field indices (EVT_REP=10, EVT_MAKE=9, EVT_EXT=8, EVT_CODE=7:0).
//  - Sub-module evt_fifo (sync, show-ahead, DEPTH/WIDTH params, level + full/empty).
//  - Top: parser FSM, prefix timer, key map, repeat timer, push arbitration.
// TESTING
//  - Bytes 1C; F0 1C, evt_ready=1 -> events 0x21C then 0x01C; key_down[0x1C] 1 then 0.
//  - E0 75; E0 F0 75 -> key_down[0x175] set/cleared; events 0x375, 0x175; last_change 0x175.
//  - REPEAT_DELAY=20, REPEAT_RATE=5: make 29 held 40 cycles -> repeats 0x629 at +21,+26,+31,+36;
//    F0 29 stops repeats.
//  - FIFO_DEPTH=4, evt_ready=0, 5 makes -> level 4, overflow=1, head = first event; ovf_clr -> 0.
//  - E0 then idle PREFIX_TIMEOUT+1 cycles, then 74 -> event 0x274 (ext dropped).
//  - Hold 1C, 1D; send AA -> key_down all 0, no event, repeat cancelled; rst_n low mid F0 -> all 0.

Source files
------------

// File: rtl/ps2_key_event_decoder_pkg.sv
// Shared scan-code constants, parser state encoding and event field layout
// for the PS/2 set-2 key event decoder.
package ps2_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;
    localparam logic [7:0] SC_BAT = 8'hAA;

    localparam int EVT_W       = 11;
    localparam int EVT_REP     = 10;
    localparam int EVT_MAKE    = 9;
    localparam int EVT_EXT     = 8;
    localparam int EVT_CODE_HI = 7;
    localparam int EVT_CODE_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } parse_state_t;

    // Device responses and pause/overrun bytes that never form a key code
    function automatic logic is_ignored(input logic [7:0] b);
        return b inside {8'hE1, 8'hFA, 8'hFE, 8'hEE, 8'hFC, 8'h00, 8'hFF};
    endfunction

endpackage

// File: rtl/ps2_key_event_decoder_evt_fifo.sv
// Show-ahead event FIFO: head entry is presented directly from storage so a
// push into an empty queue is visible on the next cycle.
module evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      level_reg, level_next;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == AW'(gi)))
                    mem_reg[gi] <= push_data;
            end
        end
    endgenerate

    always_comb begin
        level_next = level_reg;
        case ({do_push, do_pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg <= level_next;
        end
    end

    assign head_data = empty ? '0 : mem_reg[rd_ptr_reg];
    assign level     = level_reg;

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 byte stream decoder: prefix parser, 512-key down map, host-side
// typematic repeat and a valid/ready event queue.
module ps2_key_event_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int REPEAT_DELAY   = 50_000_000,
    parameter int REPEAT_RATE    = 10_000_000,
    parameter int PREFIX_TIMEOUT = 2_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    output logic [511:0]                  key_down,
    output logic [8:0]                    last_change,
    output logic                          evt_valid,
    output logic [10:0]                   evt_data,
    input  logic                          evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    parse_state_t state_reg, state_next;
    logic [31:0]  pfx_cnt_reg, pfx_cnt_next;
    logic [511:0] key_down_reg, key_down_next;
    logic [8:0]   last_change_reg;
    logic         rep_active_reg, rep_active_next;
    logic [8:0]   rep_key_reg, rep_key_next;
    logic [31:0]  rep_cnt_reg, rep_cnt_next;
    logic         overflow_reg;

    logic             cur_ext, cur_brk, bat, code_done, accept, make;
    logic [8:0]       key_idx;
    logic             rep_due, rep_fire, push;
    logic [EVT_W-1:0] push_data;
    logic             fifo_full, fifo_empty;

    // Parser FSM and prefix timer
    always_comb begin
        state_next   = state_reg;
        pfx_cnt_next = pfx_cnt_reg;
        if (rx_valid) begin
            if (rx_data == SC_EXT) begin
                pfx_cnt_next = 32'(PREFIX_TIMEOUT);
                if (state_reg == ST_IDLE)     state_next = ST_EXT;
                else if (state_reg == ST_BRK) state_next = ST_EXT_BRK;
            end else if (rx_data == SC_BRK) begin
                pfx_cnt_next = 32'(PREFIX_TIMEOUT);
                if (state_reg == ST_IDLE)     state_next = ST_BRK;
                else if (state_reg == ST_EXT) state_next = ST_EXT_BRK;
            end else begin
                state_next = ST_IDLE;
            end
        end else if (state_reg != ST_IDLE) begin
            if (pfx_cnt_reg == '0) state_next = ST_IDLE;
            else                   pfx_cnt_next = pfx_cnt_reg - 1'b1;
        end
    end

    always_comb begin
        cur_ext   = (state_reg == ST_EXT) || (state_reg == ST_EXT_BRK);
        cur_brk   = (state_reg == ST_BRK) || (state_reg == ST_EXT_BRK);
        make      = !cur_brk;
        key_idx   = {cur_ext, rx_data};
        bat       = rx_valid && (state_reg == ST_IDLE) && (rx_data == SC_BAT);
        code_done = rx_valid && (rx_data != SC_EXT) && (rx_data != SC_BRK)
                    && !bat && !is_ignored(rx_data);
        // Device typematic makes and stray breaks leave the map untouched
        accept    = code_done && (key_down_reg[key_idx] != make);
    end

    // Repeat counter reaching zero this cycle (1) or held at zero (0) is due
    always_comb begin
        rep_active_next = rep_active_reg;
        rep_key_next    = rep_key_reg;
        rep_cnt_next    = rep_cnt_reg;
        rep_fire        = 1'b0;
        rep_due         = rep_active_reg && (rep_cnt_reg <= 32'd1)
                          && key_down_reg[rep_key_reg];
        if (bat) begin
            rep_active_next = 1'b0;
            rep_cnt_next    = '0;
        end else if (accept && make) begin
            rep_active_next = (REPEAT_DELAY != 0);
            rep_key_next    = key_idx;
            rep_cnt_next    = 32'(REPEAT_DELAY);
        end else if (accept && (key_idx == rep_key_reg)) begin
            rep_active_next = 1'b0;
            rep_cnt_next    = '0;
        end else if (rep_due) begin
            if (accept) begin
                rep_cnt_next = '0;
            end else begin
                rep_fire     = 1'b1;
                rep_cnt_next = 32'(REPEAT_RATE);
            end
        end else if (rep_active_reg && (rep_cnt_reg != '0)) begin
            rep_cnt_next = rep_cnt_reg - 1'b1;
        end
    end

    always_comb begin
        push_data = '0;
        push      = accept || rep_fire;
        if (accept) begin
            push_data[EVT_MAKE] = make;
            push_data[EVT_EXT]  = key_idx[8];
            push_data[EVT_CODE_HI:EVT_CODE_LO] = key_idx[7:0];
        end else begin
            push_data[EVT_REP]  = 1'b1;
            push_data[EVT_MAKE] = 1'b1;
            push_data[EVT_EXT]  = rep_key_reg[8];
            push_data[EVT_CODE_HI:EVT_CODE_LO] = rep_key_reg[7:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 512; gi++) begin : g_keymap
            assign key_down_next[gi] = bat ? 1'b0 :
                                       (accept && (key_idx == 9'(gi))) ? make :
                                       key_down_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            pfx_cnt_reg     <= '0;
            key_down_reg    <= '0;
            last_change_reg <= '0;
            rep_active_reg  <= 1'b0;
            rep_key_reg     <= '0;
            rep_cnt_reg     <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pfx_cnt_reg    <= pfx_cnt_next;
            key_down_reg   <= key_down_next;
            rep_active_reg <= rep_active_next;
            rep_key_reg    <= rep_key_next;
            rep_cnt_reg    <= rep_cnt_next;
            if (accept) last_change_reg <= key_idx;
            if (push && fifo_full && !evt_ready) overflow_reg <= 1'b1;
            else if (ovf_clr)                    overflow_reg <= 1'b0;
        end
    end

    evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (evt_ready),
        .head_data (evt_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid   = !fifo_empty;
    assign key_down    = key_down_reg;
    assign last_change = last_change_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed and random stimulus for the PS/2 key event decoder, checked every
// cycle against a timestamp-based behavioural model.
module tb_ps2_key_event_decoder;

    localparam int DEPTH = 4;
    localparam int DLY   = 20;
    localparam int RATE  = 5;
    localparam int TMO   = 30;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         evt_ready = 1'b0;
    logic         ovf_clr = 1'b0;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         evt_valid;
    logic [10:0]  evt_data;
    logic [2:0]   fifo_level;
    logic         overflow;

    ps2_key_event_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .REPEAT_DELAY   (DLY),
        .REPEAT_RATE    (RATE),
        .PREFIX_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .key_down    (key_down),
        .last_change (last_change),
        .evt_valid   (evt_valid),
        .evt_data    (evt_data),
        .evt_ready   (evt_ready),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: pending prefixes stamped with the cycle they arrived, repeat as an absolute due cycle
    bit           m_ext, m_brk;
    longint       m_pcyc;
    bit [511:0]   m_key;
    bit [8:0]     m_last;
    bit [10:0]    q[$];
    bit           m_ovf, m_rep_on;
    bit [8:0]     m_rep_key;
    longint       m_rep_due;
    longint       cyc;

    logic [7:0] pool [13] = '{8'hE0, 8'hF0, 8'hAA, 8'h1C, 8'h1D, 8'h29, 8'h75,
                              8'h74, 8'hE1, 8'hFA, 8'h00, 8'hFF, 8'h5A};

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_ext = 0; m_brk = 0; m_pcyc = 0; m_key = '0; m_last = '0;
        q.delete(); m_ovf = 0; m_rep_on = 0; m_rep_key = '0; m_rep_due = 0;
    endtask

    task automatic m_step(input bit v, input bit [7:0] b, input bit rdy, input bit clr);
        bit        have;
        bit [10:0] ev;
        bit [8:0]  idx;
        bit        mk;
        bit        drop;
        cyc++;
        have = 0; ev = '0; drop = 0;
        if ((m_ext || m_brk) && (cyc - m_pcyc > TMO + 1)) begin
            m_ext = 0; m_brk = 0;
        end
        if (v) begin
            if (b == 8'hE0) begin
                m_ext = 1; m_pcyc = cyc;
            end else if (b == 8'hF0) begin
                m_brk = 1; m_pcyc = cyc;
            end else if (b == 8'hAA && !m_ext && !m_brk) begin
                m_key = '0; m_rep_on = 0;
            end else if (b inside {8'hE1, 8'hFA, 8'hFE, 8'hEE, 8'hFC, 8'h00, 8'hFF}) begin
                m_ext = 0; m_brk = 0;
            end else begin
                idx = {m_ext, b};
                mk  = !m_brk;
                m_ext = 0; m_brk = 0;
                if (m_key[idx] != mk) begin
                    m_key[idx] = mk;
                    m_last = idx;
                    ev = {1'b0, mk, idx};
                    have = 1;
                    if (mk && DLY != 0) begin
                        m_rep_on = 1; m_rep_key = idx; m_rep_due = cyc + DLY;
                    end else if (!mk && m_rep_on && idx == m_rep_key) begin
                        m_rep_on = 0;
                    end
                end
            end
        end
        if (!have && m_rep_on && cyc >= m_rep_due && m_key[m_rep_key]) begin
            ev = {2'b11, m_rep_key};
            have = 1;
            m_rep_due = cyc + RATE;
        end
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (have) begin
            if (q.size() < DEPTH) q.push_back(ev);
            else drop = 1;
        end
        if (drop)     m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic check_all();
        chk("evt_valid", evt_valid, q.size() > 0);
        if (q.size() > 0) chk("evt_data", evt_data, q[0]);
        chk("fifo_level", fifo_level, q.size());
        chk("overflow", overflow, m_ovf);
        chk("last_change", last_change, m_last);
        chk("key_down", key_down, m_key);
    endtask

    task automatic tick(input bit v, input logic [7:0] b);
        rx_valid = v;
        rx_data  = b;
        @(posedge clk);
        m_step(v, b, evt_ready, ovf_clr);
        #1;
        rx_valid = 0;
        check_all();
        $display("cyc=%0d rx=%0b/%h rdy=%0b valid=%0b data=%h level=%0d ovf=%0b",
                 cyc, v, b, evt_ready, evt_valid, evt_data, fifo_level, overflow);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_key_down"}, key_down, '0);
        chk({tag, "_last"}, last_change, '0);
        chk({tag, "_valid"}, evt_valid, '0);
        chk({tag, "_data"}, evt_data, '0);
        chk({tag, "_level"}, fifo_level, '0);
        chk({tag, "_ovf"}, overflow, '0);
    endtask

    initial begin
        int got[$];
        int exp_off[4] = '{21, 26, 31, 36};
        int n;
        cyc = 0;
        m_reset();
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        // Plain make / break
        evt_ready = 1;
        tick(1, 8'h1C);
        chk("mk1c_evt", evt_data, 11'h21C);
        chk("mk1c_kd", key_down[9'h01C], 1'b1);
        tick(1, 8'hF0);
        tick(1, 8'h1C);
        chk("brk1c_evt", evt_data, 11'h01C);
        chk("brk1c_kd", key_down[9'h01C], 1'b0);

        // Extended make / break
        tick(1, 8'hE0);
        tick(1, 8'h75);
        chk("mk175_evt", evt_data, 11'h375);
        chk("mk175_kd", key_down[9'h175], 1'b1);
        tick(1, 8'hE0);
        tick(1, 8'hF0);
        tick(1, 8'h75);
        chk("brk175_evt", evt_data, 11'h175);
        chk("brk175_kd", key_down[9'h175], 1'b0);
        chk("brk175_last", last_change, 9'h175);

        // Typematic repeat
        tick(1, 8'h29);
        chk("mk29_evt", evt_data, 11'h229);
        for (int k = 1; k <= 38; k++) begin
            tick(0, 8'h00);
            if (evt_valid && evt_data == 11'h629) got.push_back(k + 1);
        end
        chk("rep_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) chk("rep_offset", got[i], exp_off[i]);
        tick(1, 8'hF0);
        tick(1, 8'h29);
        chk("brk29_evt", evt_data, 11'h029);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            tick(0, 8'h00);
            if (evt_valid && evt_data == 11'h629) n++;
        end
        chk("rep_stopped", n, 0);

        // Overflow with a stalled consumer
        evt_ready = 0;
        tick(1, 8'h15);
        tick(1, 8'h16);
        tick(1, 8'h1E);
        tick(1, 8'h26);
        tick(1, 8'h25);
        chk("ovf_level", fifo_level, 3'd4);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_head", evt_data, 11'h215);
        ovf_clr = 1;
        tick(0, 8'h00);
        ovf_clr = 0;
        chk("ovf_clr", overflow, 1'b0);
        evt_ready = 1;
        tick(1, 8'hAA);
        repeat (6) tick(0, 8'h00);

        // Prefix timeout discards the pending E0
        tick(1, 8'hE0);
        repeat (TMO + 1) tick(0, 8'h00);
        tick(1, 8'h74);
        chk("tmo_evt", evt_data, 11'h274);
        chk("tmo_kd074", key_down[9'h074], 1'b1);
        chk("tmo_kd174", key_down[9'h174], 1'b0);
        tick(1, 8'hF0);
        tick(1, 8'h74);

        // BAT clears the map and cancels repeat
        tick(1, 8'h1C);
        tick(1, 8'h1D);
        tick(0, 8'h00);
        tick(1, 8'hAA);
        chk("bat_kd", key_down, '0);
        chk("bat_noevt", evt_valid, 1'b0);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            tick(0, 8'h00);
            if (evt_valid) n++;
        end
        chk("bat_norep", n, 0);

        // Asynchronous reset in the middle of a break sequence
        tick(1, 8'h1C);
        tick(1, 8'hF0);
        #2;
        rst_n = 0;
        #1;
        m_reset();
        check_zero("midrst");
        @(negedge clk);
        rst_n = 1;
        tick(1, 8'h1C);
        chk("postrst_evt", evt_data, 11'h21C);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            evt_ready = ($urandom_range(0, 9) < 7);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            tick($urandom_range(0, 2) == 0, pool[$urandom_range(0, 12)]);
        end
        ovf_clr = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
